// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
//   DATA_W         : datapath bus width.
//   OUTPORT_DEPTH  : default number of entries in the output port FIFO.
//   word_t         : one bus word.
//   outport_state_t: two-state view of the output FIFO head (EMPTY / HAS_DATA),
//                    derived from occupancy; used by assertions and coverage.
package cpu_pkg;

    localparam int DATA_W        = 32;
    localparam int OUTPORT_DEPTH = 8;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        EMPTY    = 1'b0,
        HAS_DATA = 1'b1
    } outport_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array for small synchronous FIFOs.
// Ports:
//   clk   : clock; writes happen on the rising edge.
//   we    : write enable.
//   waddr : write address.
//   wdata : write data.
//   raddr : read address.
//   rdata : combinational read data, mem[raddr].
// Contents are deliberately not reset; the owning FIFO tracks validity.
module sync_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// CPU output port with a DEPTH-entry FIFO between the datapath bus and a
// device. OutPortin captures BusMuxOut; the device drains words over a
// valid/ready handshake.
// Ports:
//   Clock      : system clock, rising edge.
//   Clear      : synchronous active-high reset; wins over any write or pop.
//   OutPortin  : write strobe; BusMuxOut is captured if there is room
//                (or a pop frees a slot in the same cycle).
//   BusMuxOut  : datapath bus.
//   dev_data   : head word (0 while empty).
//   dev_valid  : head word present.
//   dev_ready  : device accepts the head word.
//   Stall      : FIFO full; the control unit holds its OUT step.
//   overflow   : sticky, set when a write is dropped, cleared by Clear.
//   count      : occupancy 0..DEPTH.
//   legacy_out : only when OUT_PORT_LEGACY_REG_EN is defined; last word strobed
//                by OutPortin (dropped writes included), like the old
//                single-register output port.
//
// Handshake: a word transfers at a rising edge where dev_valid=1 and
// dev_ready=1. dev_valid only falls after such a transfer (or Clear), and
// dev_data holds steady while dev_valid=1 and dev_ready=0. dev_ready is
// ignored while empty.
module out_port_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = OUTPORT_DEPTH,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             OutPortin,
    input  logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] dev_data,
    output logic             dev_valid,
    input  logic             dev_ready,
    output logic             Stall,
    output logic             overflow,
`ifdef OUT_PORT_LEGACY_REG_EN
    output logic [WIDTH-1:0] legacy_out,
`endif
    output logic [CNTW-1:0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q,  count_d;
    logic            overflow_q, overflow_d;
`ifdef OUT_PORT_LEGACY_REG_EN
    logic [WIDTH-1:0] legacy_q, legacy_d;
`endif

    outport_state_t  head_state;
    logic            full;
    logic            push;
    logic            pop;
    logic [WIDTH-1:0] rdata;

    assign head_state = (count_q != '0) ? HAS_DATA : EMPTY;
    assign full       = (count_q == CNTW'(DEPTH));
    assign pop        = (head_state == HAS_DATA) && dev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = OutPortin && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        if (OutPortin && !push) begin
            overflow_d = 1'b1;
        end
    end

`ifdef OUT_PORT_LEGACY_REG_EN
    always_comb begin
        legacy_d = legacy_q;
        if (OutPortin) begin
            legacy_d = BusMuxOut;
        end
    end
`endif

    always_ff @(posedge Clock) begin
        if (Clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef OUT_PORT_LEGACY_REG_EN
            legacy_q   <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef OUT_PORT_LEGACY_REG_EN
            legacy_q   <= legacy_d;
`endif
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (Clock),
        .we    (push && !Clear),
        .waddr (wr_ptr_q),
        .wdata (BusMuxOut),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign dev_valid = (head_state == HAS_DATA);
    assign dev_data  = dev_valid ? rdata : '0;
    assign Stall     = full;
    assign overflow  = overflow_q;
    assign count     = count_q;
`ifdef OUT_PORT_LEGACY_REG_EN
    assign legacy_out = legacy_q;
`endif

endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
- Parametrised successor to the single-register output port.
- CPU side: the OutPortin control strobe captures BusMuxOut into a DEPTH-entry FIFO instead of overwriting one register.
- Device side: drains words over a valid/ready handshake, so slow peripherals no longer lose data.
- Sits on the datapath bus beside the input port; exposes a Stall flag to the control unit and a sticky overflow flag.

Parameters:
- WIDTH, 32, data width of the bus and the device.
- DEPTH, 8, FIFO entries; must be a power of two, ≥2.
- CNTW, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  synchronous active-high reset.
- OutPortin  in  1  write strobe from the control unit.
- BusMuxOut  in  WIDTH  datapath bus; sampled when OutPortin=1.
- dev_data  out  WIDTH  head-of-FIFO word to the device.
- dev_valid  out  1  head word present.
- dev_ready  in  1  device accepts the head word.
- Stall  out  1  FIFO full; the control unit must hold its OUT step.
- overflow  out  1  sticky: a write was dropped.
- count  out  CNTW  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, Clock; reset is synchronous and active-high, on port Clear.
- Reset (Clear=1 at an edge): rd_ptr=wr_ptr=0, count=0, dev_valid=0, Stall=0, overflow=0.
  - dev_data reads 0 after reset; storage array contents are not cleared.
  - Clear has priority over every simultaneous write or pop.
- Push: an edge with OutPortin=1 and (count<DEPTH or pop in the same cycle).
  - mem[wr_ptr] <= BusMuxOut; wr_ptr increments modulo DEPTH.
- Pop: an edge with dev_valid=1 and dev_ready=1; rd_ptr increments modulo DEPTH.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- Occupancy update:
  - push only: count+1.
  - pop only: count−1.
  - both, or neither: unchanged.
- Outputs, all combinational from registers:
  - dev_valid = (count!=0).
  - dev_data = mem[rd_ptr] when dev_valid, else 0.
  - Stall = (count==DEPTH).
- Latency: a word written into an empty FIFO at edge N appears on dev_data with dev_valid=1 immediately after edge N (one-cycle write-to-valid).
- Full with write and pop in the same cycle: the write is accepted and count stays DEPTH.
- Full with write and no pop: the write is dropped; overflow <= 1 and stays 1 until Clear.
- Empty with dev_ready=1: no pop, count stays 0; dev_ready is ignored.
- Empty with a write at the same edge: the write is accepted; no same-cycle bypass (dev_valid rises after the edge).
- Device handshake: dev_valid never drops without a pop; dev_data is stable while dev_valid=1 and dev_ready=0.
- Internal two-state view of the head, EMPTY ↔ HAS_DATA, derived from count:
  - EMPTY→HAS_DATA on a push.
  - HAS_DATA→EMPTY on a pop when count==1 and there is no push.
- Clear asserted mid-drain: all queued words are discarded and dev_valid falls after that edge.

Optional Feature:
- Macro: OUT_PORT_LEGACY_REG_EN.
- Defined: an extra output port legacy_out [WIDTH-1:0].
  - Register loaded with BusMuxOut on every OutPortin edge, including dropped writes.
  - Cleared by Clear.
  - Reproduces the previous single-register output port for old testbenches and board LEDs.
- Undefined: the port and register do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W=32.
  - OUTPORT_DEPTH default.
  - typedef word_t = logic [DATA_W-1:0].
  - typedef enum {EMPTY, HAS_DATA} outport_state_t, for assertions and coverage.
- One natural sub-module, sync_fifo_mem: the DEPTH×WIDTH register array with write port and combinational read port.
  - The input port successor will reuse it.
- Pointers, count, flags and handshake logic stay in out_port_fifo.

Test Plan:
- Reset, then write 0x0000000A with dev_ready=0 → next cycle dev_valid=1, dev_data=0x0000000A, count=1.
- DEPTH=8: write 0x1..0x8 with dev_ready=0 → Stall=1, count=8.
  - Then write 0x9 → dropped, overflow=1.
  - Then drain with dev_ready=1 → words read out in order 0x1..0x8, count returns to 0, dev_valid=0.
- Full FIFO: write 0xAA with dev_ready=1 in the same cycle → 0x1 popped, 0xAA accepted, count stays 8, overflow unchanged.
- Stream 20 words with dev_ready toggling every cycle → all 20 words received in order, pointers wrap twice, dev_data stable during each stall.
- Queue 0x5 and 0x6, then assert Clear for 1 cycle → count=0, dev_valid=0, overflow=0.
  - Next write 0x7 → dev_data=0x7.
- With OUT_PORT_LEGACY_REG_EN: write 0x1..0x9 into a full FIFO → legacy_out=0x9 while the FIFO holds 0x1..0x8.
